// File: rtl/divider_pipe.sv
// divider_pipe: N-stage restoring integer divider, one quotient bit per stage, tag and div0 carried alongside.
// Define DIVIDER_PIPE_SIGNED_EN for two's-complement operands (quotient truncates toward zero).
module divider_pipe #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_dividend,
  input  logic [M-1:0]     in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_quotient,
  output logic [M-1:0]     out_remainder,
  output logic             out_div0,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a port transfers on valid && ready. in_ready = !(out_valid && !out_ready)
  // and never looks at in_valid; while stalled every stage, valid bits included, holds.
  logic                     stall;
  logic [N-1:0]             v_q;
  logic [N-1:0]             div0_q;
  logic [N-1:0][M-1:0]      r_q;
  logic [N-1:0][M-1:0]      lo_q;
  logic [N-1:0][N-1:0]      acc_q;
  logic [N-2:0][M-1:0]      dvs_q;
  logic [N-1:0][TAG_W-1:0]  tag_q;
  logic [N-1:0][M-1:0]      r_d;
  logic [N-1:0][N-1:0]      acc_d;
  logic [N-1:0]             e_dividend;
  logic [M-1:0]             e_divisor;
  logic [N-1:0]             q_res;
  logic [M-1:0]             r_res;

  assign stall    = v_q[N-1] && !out_ready;
  assign in_ready = !stall;

`ifdef DIVIDER_PIPE_SIGNED_EN
  logic [N-1:0] qneg_q;
  logic [N-1:0] rneg_q;
  logic         e_qneg;
  logic         e_rneg;

  always_comb begin
    e_rneg     = in_dividend[N-1];
    e_qneg     = in_dividend[N-1] ^ in_divisor[M-1];
    e_dividend = e_rneg ? -in_dividend : in_dividend;
    e_divisor  = in_divisor[M-1] ? -in_divisor : in_divisor;
  end
`else
  assign e_dividend = in_dividend;
  assign e_divisor  = in_divisor;
`endif

  // acc shifts dividend bits out of the top while quotient bits enter at the bottom.
  function automatic logic [M+N-1:0] step(input logic [M-1:0] r, input logic [N-1:0] acc,
                                          input logic [M-1:0] d);
    logic [M:0] t;
    logic       qb;
    t  = {r, acc[N-1]};
    qb = (t >= {1'b0, d});
    if (qb) t = t - {1'b0, d};
    return {t[M-1:0], acc[N-2:0], qb};
  endfunction

  always_comb begin
    {r_d[0], acc_d[0]} = step('0, e_dividend, e_divisor);
    for (int k = 1; k < N; k++) begin
      {r_d[k], acc_d[k]} = step(r_q[k-1], acc_q[k-1], dvs_q[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      div0_q <= '0;
      r_q    <= '0;
      lo_q   <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
      tag_q  <= '0;
`ifdef DIVIDER_PIPE_SIGNED_EN
      qneg_q <= '0;
      rneg_q <= '0;
`endif
    end else if (!stall) begin
      v_q      <= {v_q[N-2:0], in_valid};
      div0_q   <= {div0_q[N-2:0], (in_divisor == '0)};
      r_q      <= r_d;
      acc_q    <= acc_d;
      lo_q     <= {lo_q[N-2:0], in_dividend[M-1:0]};
      tag_q    <= {tag_q[N-2:0], in_tag};
      dvs_q[0] <= e_divisor;
      for (int k = 1; k < N - 1; k++) dvs_q[k] <= dvs_q[k-1];
`ifdef DIVIDER_PIPE_SIGNED_EN
      qneg_q   <= {qneg_q[N-2:0], e_qneg};
      rneg_q   <= {rneg_q[N-2:0], e_rneg};
`endif
    end
  end

  // Sign fix-up and the divide-by-zero override both live at the output stage.
  always_comb begin
`ifdef DIVIDER_PIPE_SIGNED_EN
    q_res = qneg_q[N-1] ? -acc_q[N-1] : acc_q[N-1];
    r_res = rneg_q[N-1] ? -r_q[N-1] : r_q[N-1];
`else
    q_res = acc_q[N-1];
    r_res = r_q[N-1];
`endif
    out_valid     = v_q[N-1];
    out_div0      = div0_q[N-1];
    out_tag       = tag_q[N-1];
    out_quotient  = div0_q[N-1] ? '1 : q_res;
    out_remainder = div0_q[N-1] ? lo_q[N-1] : r_res;
  end

endmodule

// File: tb/tb_divider_pipe.sv
// tb_divider_pipe: directed vectors, arithmetic reference model with an expected queue, per-cycle compare.
// Honours DIVIDER_PIPE_SIGNED_EN in the same way as the design.
module tb_divider_pipe;
  localparam int N     = 8;
  localparam int M     = 4;
  localparam int TAG_W = 4;
  localparam int W     = N + M + 1 + TAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_dividend = '0;
  logic [M-1:0]     in_divisor = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N-1:0]     out_quotient;
  logic [M-1:0]     out_remainder;
  logic             out_div0;
  logic [TAG_W-1:0] out_tag;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  divider_pipe #(.N(N), .M(M), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div0(out_div0), .out_tag(out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [M-1:0] b,
                                         input logic [TAG_W-1:0] t);
    int sa;
    int sb;
    int qi;
    int ri;
    logic [N-1:0] q;
    logic [M-1:0] r;
    if (b == '0) begin
      q = '1;
      r = a[M-1:0];
      return {q, r, 1'b1, t};
    end
`ifdef DIVIDER_PIPE_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    qi = sa / sb;
    ri = sa % sb;
    q  = qi[N-1:0];
    r  = ri[M-1:0];
    return {q, r, 1'b0, t};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {out_quotient, out_remainder, out_div0, out_tag};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] a, input logic [M-1:0] b, input logic [TAG_W-1:0] t);
    int guard;
    guard       = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) break;
    end
    if (guard > 200) begin
      check("send_timeout", 32'd1, 32'd0);
    end else begin
      exp_q.push_back(model(a, b, t));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid; returns 0 if it never arrives.
  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("wait_out_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // ---------------- scoreboard / compare ----------------
  logic         prev_stall = 1'b0;
  logic [W:0]   held;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) check("stall_hold", {out_valid, dut_out()}, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("result", dut_out(), exp_q.pop_front());
          pops++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_valid, dut_out()};
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0]     bp_a[8] = '{8'd0, 8'd1, 8'd255, 8'd128, 8'd77, 8'd16, 8'd99, 8'd254};
  logic [M-1:0]     bp_b[8] = '{4'd1, 4'd15, 4'd2, 4'd3, 4'd0, 4'd4, 4'd9, 4'd8};

  initial begin
    int lat;
    int stale;
    int pops0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 32'd0);
    check("reset_quotient", out_quotient, 32'd0);
    check("reset_remainder", out_remainder, 32'd0);
    check("reset_div0", out_div0, 32'd0);
    check("reset_tag", out_tag, 32'd0);
    check("reset_in_ready", in_ready, 32'd1);
    @(posedge clk);
    #1;

    // Basic: 200 / 7 = 28 r 4
    send(8'd200, 4'd7, 4'd3);
    wait_out(lat);
    check("basic_latency", lat, 32'd8);
    check("basic_quotient", out_quotient, 32'h1C);
    check("basic_remainder", out_remainder, 32'd4);
    check("basic_div0", out_div0, 32'd0);
    check("basic_tag", out_tag, 32'd3);
    @(posedge clk);
    #1;

    // Back-to-back, results on consecutive cycles in order
    send(8'd255, 4'd15, 4'd1);
    send(8'd9, 4'd3, 4'd2);
    send(8'd0, 4'd5, 4'd4);
    wait_out(lat);
    check("b2b_q0", {out_quotient, out_remainder, out_tag}, {8'd17, 4'd0, 4'd1});
    @(negedge clk);
    check("b2b_q1", {out_valid, out_quotient, out_remainder, out_tag}, {1'b1, 8'd3, 4'd0, 4'd2});
    @(negedge clk);
    check("b2b_q2", {out_valid, out_quotient, out_remainder, out_tag}, {1'b1, 8'd0, 4'd0, 4'd4});
    @(posedge clk);
    #1;

    // Divide by zero
    send(8'd13, 4'd0, 4'd5);
    wait_out(lat);
    check("div0_quotient", out_quotient, 32'hFF);
    check("div0_remainder", out_remainder, 32'hD);
    check("div0_flag", out_div0, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: 8-op stream, out_ready low for 5 cycles mid-stream
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], TAG_W'(i + 8));
      end
      begin
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", pops - pops0, 32'd8);

    // Reset with operations in flight
    for (int i = 0; i < 4; i++) send(8'(40 + i), 4'd3, TAG_W'(i));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", out_valid, 32'd0);
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 32'd0);
    @(posedge clk);
    #1;
    send(8'd100, 4'd9, 4'd6);
    wait_out(lat);
    check("post_rst_latency", lat, 32'd8);
    check("post_rst_result", {out_quotient, out_remainder, out_tag}, {8'd11, 4'd1, 4'd6});
    @(posedge clk);
    #1;

`ifdef DIVIDER_PIPE_SIGNED_EN
    send(8'h9C, 4'd7, 4'd1);
    wait_out(lat);
    check("s_neg_dividend", {out_quotient, out_remainder}, {8'hF2, 4'hE});
    @(posedge clk);
    #1;
    send(8'd100, 4'h9, 4'd2);
    wait_out(lat);
    check("s_neg_divisor", {out_quotient, out_remainder}, {8'hF2, 4'h2});
    @(posedge clk);
    #1;
    send(8'h80, 4'hF, 4'd3);
    wait_out(lat);
    check("s_wrap", {out_quotient, out_remainder}, {8'h80, 4'h0});
    @(posedge clk);
    #1;
`endif

    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
